ram_arbiter: RTL
================

# ram_arbiter

Two-port arbiter that shares the single-port SPI RAM between two command requesters, for example the SPI slave and an on-chip debug/host port. It accepts 10-bit command words (opcode in bits [9:8]: 00 write-address, 01 write-data, 10 read-address, 11 read-data). It keeps each address/data pair atomic on the RAM side, returns read data only to the requester that issued the read, and balances access round-robin.

## Interface
- `TIMEOUT_CYCLES`, 16: watchdog limit in cycles (used only with `RAM_ARB_TIMEOUT_EN`); legal range 2..255.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req0_din`  in  10  requester 0 command word.
- `req0_valid`  in  1  requester 0 word present.
- `req0_ready`  out  1  requester 0 word accepted this cycle (combinational).
- `rsp0_dout`  out  8  read data to requester 0.
- `rsp0_valid`  out  1  one-cycle pulse, `rsp0_dout` valid.
- `req1_din`, `req1_valid`, `req1_ready`, `rsp1_dout`, `rsp1_valid`: same as the port-0 signals, for requester 1.
- `ram_din`  out  10  command word to the RAM.
- `ram_rx_valid`  out  1  `ram_din` valid for one cycle.
- `ram_dout`  in  8  RAM read data.
- `ram_tx_valid`  in  1  RAM read data valid.
- `owner`  out  2  one-hot current grant; 00 when idle.
- `err`  out  1  one-cycle protocol-error pulse.

## Operation
- FSM states: IDLE, ADDR_HELD, WAIT_RD.
- **IDLE**
  - Only address words (00/10) are grantable.
  - If exactly one requester presents an address word, it wins.
  - If both present one, the round-robin pointer picks the winner (pointer = 0 favours requester 0).
  - Winner's `ready`=1; word is forwarded; `owner` set; go to ADDR_HELD.
- **IDLE, data word presented**
  - A requester presenting a data word (01/11) is accepted (`ready`=1), the word is dropped and `err` pulses.
  - If the other requester presents an address word in the same cycle, that address is granted in the same cycle.
- **ADDR_HELD**
  - Only the owner's `ready` may assert.
  - Matching data word (01 after 00, 11 after 10): accepted and forwarded.
    - Write (01): release the grant, flip the pointer to the other requester, go to IDLE.
    - Read (11): go to WAIT_RD.
  - Owner presents a non-matching opcode: accept, drop, pulse `err`, stay in ADDR_HELD.
  - Non-owner words stall (`ready`=0).
- **WAIT_RD**
  - No requester is accepted.
  - On `ram_tx_valid`: capture `ram_dout`, pulse the owner's `rsp_valid` with it next cycle, release the grant, flip the pointer, go to IDLE.
- `ram_tx_valid` outside WAIT_RD: ignored, `err` pulses.
- `ram_din` holds the last forwarded word while `ram_rx_valid`=0.
- Each RAM-side transaction carries exactly one requester's words: no address from one requester is ever followed by data from the other.

## Timing
- Reset values (on the `rst_n` low clock edge): `ram_din`=0, `ram_rx_valid`=0, `rsp*_dout`=0, `rsp*_valid`=0, `owner`=00, `err`=0, pointer=0, state IDLE.
- Reset mid-transaction abandons it: no response, no `err`.
- Word accepted at edge T → `ram_rx_valid`=1 with that word during cycle T+1 (one-cycle forward latency).
- Write: address at T, data at T+1 earliest; next address acceptable at T+2.
- Read: 11 accepted at T, RAM sees it at T+1, `ram_tx_valid` expected at T+2, `rsp_valid` at T+3. Next address acceptable from T+3.
- `ready` is combinational from `valid`, `din[9:8]`, state and pointer; never depends on `ram_*` inputs.
- `err` and `rsp*_valid` are registered single-cycle pulses.

## Configuration
- `RAM_ARB_TIMEOUT_EN` defined:
  - An 8-bit watchdog runs in ADDR_HELD and WAIT_RD and resets on every accepted word or `ram_tx_valid`.
  - When it reaches `TIMEOUT_CYCLES`: release the grant, flip the pointer, return to IDLE, pulse `err`.
  - An aborted read produces no `rsp_valid`.
- Macro undefined: no watchdog; the FSM waits indefinitely in ADDR_HELD/WAIT_RD; `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset held 2 cycles, then released → all outputs 0, `owner`=00; first grant with both requesting goes to requester 0.
- Both requesters issue write pairs (0x000/0x155, 0x010/0x1AA) continuously → RAM sees 000,155,010,1AA strictly paired, owners alternating 01,10,01.
- Requester 1 reads: 0x205 then 0x300, RAM returns 0x5A two cycles later → `rsp1_valid`=1 with 0x5A at T+3; `rsp0_valid` stays 0.
- Requester 0 sends 0x100 in IDLE → `err` one pulse, RAM sees nothing. Sends 0x000 then 0x300 → `err`, still ADDR_HELD, requester 1 stalled.
- `rst_n` dropped while in WAIT_RD → next cycle IDLE, `owner`=00, no `rsp_valid`, no `err`.
- With `RAM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4: send a read address with no data word → `err` pulse 4 cycles after last acceptance, `owner`=00, other requester granted next.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester and RAM-side signals of the two-port RAM arbiter.
// The arbiter takes the slave view; the environment driving requesters and
// modelling the RAM takes the master view.
interface ram_arbiter_if;
    // Requester 0
    logic [9:0] req0_din;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] rsp0_dout;
    logic       rsp0_valid;
    // Requester 1
    logic [9:0] req1_din;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] rsp1_dout;
    logic       rsp1_valid;
    // RAM side
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;

    modport slave (
        input  req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
        output req0_ready, rsp0_dout, rsp0_valid,
        output req1_ready, rsp1_dout, rsp1_valid,
        output ram_din, ram_rx_valid
    );

    modport master (
        output req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
        input  req0_ready, rsp0_dout, rsp0_valid,
        input  req1_ready, rsp1_dout, rsp1_valid,
        input  ram_din, ram_rx_valid
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port command-word RAM between two requesters.
// Address/data pairs stay atomic on the RAM side, read data returns only to the
// requester that issued the read, and contention is settled round-robin.
// Optional watchdog: define RAM_ARB_TIMEOUT_EN to abort a stalled grant after
// TIMEOUT_CYCLES cycles without progress.
//
// Handshake: a requester word transfers on a rising edge where reqN_valid and
// reqN_ready are both high. reqN_ready is combinational from reqN_valid,
// reqN_din[9:8], FSM state and the round-robin pointer (never from ram_*), and
// is only high while reqN_valid is high. The RAM side has no back-pressure:
// ram_rx_valid and ram_tx_valid are single-cycle strobes.
module ram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus,
    output logic [1:0]   owner,
    output logic         err,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_HELD = 2'd1,
        WAIT_RD   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;           // round-robin pointer, 0 favours requester 0
    logic [1:0] owner_q, owner_d;       // one-hot grant, 00 when idle
    logic       rd_q, rd_d;             // held address was a read address
    logic [9:0] ram_din_q, ram_din_d;
    logic       ram_rx_valid_q, ram_rx_valid_d;
    logic [7:0] rsp0_dout_q, rsp0_dout_d;
    logic [7:0] rsp1_dout_q, rsp1_dout_d;
    logic       rsp0_valid_q, rsp0_valid_d;
    logic       rsp1_valid_q, rsp1_valid_d;
    logic       err_q, err_d;

    logic       ready0, ready1;
    logic       win;                    // IDLE grant winner: 0 or 1
    logic       activity;               // an accepted word or RAM read data this cycle

    // Opcode bit 8 separates address words (00/10) from data words (01/11).
    logic addr0, addr1, data0, data1;
    assign addr0 = bus.req0_valid & ~bus.req0_din[8];
    assign data0 = bus.req0_valid &  bus.req0_din[8];
    assign addr1 = bus.req1_valid & ~bus.req1_din[8];
    assign data1 = bus.req1_valid &  bus.req1_din[8];

    // Owner-side view used while a grant is held.
    logic       own_id;
    logic       own_valid;
    logic [9:0] own_din;
    logic       own_match;
    assign own_id    = owner_q[1];
    assign own_valid = own_id ? bus.req1_valid : bus.req0_valid;
    assign own_din   = own_id ? bus.req1_din   : bus.req0_din;
    // A data word matches when it is the data opcode of the held address type.
    assign own_match = (own_din[9:8] == {rd_q, 1'b1});

`ifdef RAM_ARB_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
`endif

    // Next-state, grant, forwarding and error decode.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        rd_d           = rd_q;
        ram_din_d      = ram_din_q;
        ram_rx_valid_d = 1'b0;
        rsp0_dout_d    = rsp0_dout_q;
        rsp1_dout_d    = rsp1_dout_q;
        rsp0_valid_d   = 1'b0;
        rsp1_valid_d   = 1'b0;
        err_d          = 1'b0;
        ready0         = 1'b0;
        ready1         = 1'b0;
        win            = 1'b0;
        activity       = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
        wd_d           = wd_q;
`endif

        unique case (state_q)
            IDLE: begin
                // Stray data words are swallowed and flagged.
                ready0 = data0;
                ready1 = data1;
                if (data0 || data1) begin
                    err_d = 1'b1;
                end
                if (addr0 || addr1) begin
                    win = (addr0 && addr1) ? ptr_q : addr1;
                    if (win) begin
                        ready1 = 1'b1;
                    end else begin
                        ready0 = 1'b1;
                    end
                    ram_din_d      = win ? bus.req1_din : bus.req0_din;
                    ram_rx_valid_d = 1'b1;
                    rd_d           = ram_din_d[9];
                    owner_d        = win ? 2'b10 : 2'b01;
                    state_d        = ADDR_HELD;
                    activity       = 1'b1;
                end
            end

            ADDR_HELD: begin
                // Only the owner is served; the other requester stalls.
                if (own_valid) begin
                    if (own_id) begin
                        ready1 = 1'b1;
                    end else begin
                        ready0 = 1'b1;
                    end
                    activity = 1'b1;
                    if (own_match) begin
                        ram_din_d      = own_din;
                        ram_rx_valid_d = 1'b1;
                        if (rd_q) begin
                            state_d = WAIT_RD;
                        end else begin
                            owner_d = 2'b00;
                            ptr_d   = ~own_id;
                            state_d = IDLE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            WAIT_RD: begin
                if (bus.ram_tx_valid) begin
                    activity = 1'b1;
                    if (own_id) begin
                        rsp1_dout_d  = bus.ram_dout;
                        rsp1_valid_d = 1'b1;
                    end else begin
                        rsp0_dout_d  = bus.ram_dout;
                        rsp0_valid_d = 1'b1;
                    end
                    owner_d = 2'b00;
                    ptr_d   = ~own_id;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                owner_d = 2'b00;
            end
        endcase

        // RAM read data nobody is waiting for.
        if (bus.ram_tx_valid && (state_q != WAIT_RD)) begin
            err_d = 1'b1;
        end

`ifdef RAM_ARB_TIMEOUT_EN
        // Watchdog: counts cycles without progress while a grant is held.
        if ((state_q == IDLE) || activity) begin
            wd_d = 8'd0;
        end else if (wd_q == 8'(TIMEOUT_CYCLES - 1)) begin
            wd_d         = 8'd0;
            owner_d      = 2'b00;
            ptr_d        = ~own_id;
            state_d      = IDLE;
            err_d        = 1'b1;
            rsp0_valid_d = 1'b0;
            rsp1_valid_d = 1'b0;
        end else begin
            wd_d = wd_q + 8'd1;
        end
`endif
    end

`ifndef RAM_ARB_TIMEOUT_EN
    // Without the watchdog the limit and the progress flag have no consumer.
    logic [8:0] unused_cfg;
    assign unused_cfg = {activity, 8'(TIMEOUT_CYCLES)};
`endif

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= 1'b0;
            owner_q        <= 2'b00;
            rd_q           <= 1'b0;
            ram_din_q      <= 10'd0;
            ram_rx_valid_q <= 1'b0;
            rsp0_dout_q    <= 8'd0;
            rsp1_dout_q    <= 8'd0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            rd_q           <= rd_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            rsp0_dout_q    <= rsp0_dout_d;
            rsp1_dout_q    <= rsp1_dout_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_valid_q   <= rsp1_valid_d;
            err_q          <= err_d;
        end
    end

`ifdef RAM_ARB_TIMEOUT_EN
    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.ram_din      = ram_din_q;
    assign bus.ram_rx_valid = ram_rx_valid_q;
    assign bus.rsp0_dout    = rsp0_dout_q;
    assign bus.rsp0_valid   = rsp0_valid_q;
    assign bus.rsp1_dout    = rsp1_dout_q;
    assign bus.rsp1_valid   = rsp1_valid_q;
    assign owner            = owner_q;
    assign err              = err_q;
    assign dbg_state_o      = state_q;

endmodule
